cpu_reg_display: RTL and testbench
==================================

// Module: cpu_reg_display
// PURPOSE
//   Downstream consumer of MultiCycleCPU's debug outputs (a0, v0, sp, ra).
//   Shows one 16-bit register as 4 hex digits on the board's 4-digit
//   common-anode 7-segment display, time-multiplexed.
//   A debounced push-button steps through the registers.
//   Each register value is snapshotted once per scan frame, so every frame
//   shows a single value even while the CPU is running.
// PARAMETERS
//   SCAN_DIV    100000  clk cycles per digit slot; must be >=2
//   DEB_CYCLES  1000000 consecutive stable synced-button cycles to accept an edge; >=2
// PORTS
//   clk      in   1   system clock; all logic on its rising edge
//   reset    in   1   asynchronous, active-low reset
//   a0       in   16  CPU register $a0
//   v0       in   16  CPU register $v0
//   sp       in   16  CPU register $sp
//   ra       in   16  CPU register $ra
//   btn_next in   1   raw, asynchronous, active-high push-button
//   an       out  4   digit anodes, active-low; an[0] is the rightmost digit (bits [3:0])
//   seg      out  8   segments, active-low, {dp,g,f,e,d,c,b,a}; dp always 1 (off)
//   sel_led  out  4   one-hot register select: 0001=a0 0010=v0 0100=sp 1000=ra
// BEHAVIOUR
//   Reset (async, reset==0): scan_cnt=0, digit=0, sel=0 (a0), shadow=16'h0000,
//     debounce FSM=IDLE, deb_cnt=0, sync FFs=0.
//     Outputs during reset: an=4'b1110, seg=8'hC0, sel_led=4'b0001.
//     Reset asserted mid-frame or mid-debounce forces these values immediately.
//   Scan: scan_cnt counts 0..SCAN_DIV-1 and wraps.
//     On each wrap edge, digit advances 0->1->2->3->0.
//     an and seg are registered and update on the same edge as digit.
//     an = ~(4'b0001 << digit).
//   Frame boundary = wrap edge with digit==3.
//     On that edge, shadow <= register selected by sel at that edge.
//     seg for the new digit 0 uses the new shadow value.
//     Input changes between boundaries are not displayed until the next frame.
//   Decode, nibble -> seg:
//     0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8,
//     8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
//   Button path: 2-FF synchronizer -> debounce FSM on the synced signal s.
//     IDLE:  s==1 -> PRESS_WAIT, deb_cnt=0.
//     PRESS_WAIT: s==0 -> IDLE.
//       Otherwise deb_cnt++; when deb_cnt reaches DEB_CYCLES-1 -> PRESSED,
//       and sel <= sel+1 mod 4 (ra wraps to a0). This is the only sel-update point.
//     PRESSED: s==0 -> RELEASE_WAIT, deb_cnt=0. Holding causes no further steps.
//     RELEASE_WAIT: s==1 -> PRESSED.
//       Otherwise deb_cnt++; when deb_cnt reaches DEB_CYCLES-1 -> IDLE.
//   sel_led is registered from sel and changes on the same edge as sel.
//   Press accepted on a frame-boundary edge: the snapshot uses the old sel;
//     the new register appears from the next frame; sel_led updates at once.
//   Frame period = 4*SCAN_DIV cycles. Display latency from a register change:
//     at most one frame plus the time to the next boundary.
// TESTING  (bench params: SCAN_DIV=4, DEB_CYCLES=8; all else idle unless stated)
//   1. Reset held low, then released ->
//      an=1110, seg=C0, sel_led=0001; an unchanged for 4 cycles, then 1101.
//   2. a0=16'h1A2F from reset; after the first boundary (edge 16) ->
//      digit slots show (1110,8E) (1101,A4) (1011,88) (0111,F9), then repeat.
//   3. a0 changed to 16'h0000 after digit 0 of a 1A2F frame ->
//      digits 1..3 still A4,88,F9; the next frame shows all C0.
//   4. btn_next pulses of 3 and 7 cycles -> sel_led stays 0001.
//      Held for 100 cycles -> exactly one step to 0010.
//      Four clean presses total -> back to 0001.
//   5. sp=16'hBEEF and two presses (sel_led=0100) ->
//      the next full frame shows 8E,86,86,83 on an 1110,1101,1011,0111.
//   6. reset pulsed low mid-frame and mid-PRESS_WAIT ->
//      an=1110, seg=C0, sel_led=0001 asynchronously;
//      no sel step occurs after release.

Source files
------------

// File: rtl/cpu_reg_display.sv
// ============================================================================
// Module   : cpu_reg_display
// Purpose  : Shows one of four 16-bit CPU debug registers on a 4-digit
//            common-anode 7-segment display. A debounced button selects
//            the register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_reg_display #(
    parameter int SCAN_DIV   = 100000,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] a0,
    input  logic [15:0] v0,
    input  logic [15:0] sp,
    input  logic [15:0] ra,
    input  logic        btn_next,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic [3:0]  sel_led
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } deb_state_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0:    s = 8'hC0;
            4'h1:    s = 8'hF9;
            4'h2:    s = 8'hA4;
            4'h3:    s = 8'hB0;
            4'h4:    s = 8'h99;
            4'h5:    s = 8'h92;
            4'h6:    s = 8'h82;
            4'h7:    s = 8'hF8;
            4'h8:    s = 8'h80;
            4'h9:    s = 8'h90;
            4'hA:    s = 8'h88;
            4'hB:    s = 8'h83;
            4'hC:    s = 8'hC6;
            4'hD:    s = 8'hA1;
            4'hE:    s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        digit_q, digit_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        sel_led_q, sel_led_d;
    logic              sync1_q, sync2_q;
    deb_state_t        state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;

    logic              wrap;
    logic              boundary;
    logic              step;
    logic [15:0]       sel_reg;
    logic [3:0]        nibble;

    always_comb begin
        case (sel_q)
            2'd0:    sel_reg = a0;
            2'd1:    sel_reg = v0;
            2'd2:    sel_reg = sp;
            default: sel_reg = ra;
        endcase
    end

    // The snapshot is taken on the same edge that moves to digit 0, so the
    // nibble for the new digit is read from the next-state shadow.
    always_comb begin
        wrap       = (scan_cnt_q == SCAN_MAX);
        scan_cnt_d = wrap ? '0 : scan_cnt_q + 1'b1;
        digit_d    = wrap ? digit_q + 2'd1 : digit_q;
        boundary   = wrap && (digit_q == 2'd3);
        shadow_d   = boundary ? sel_reg : shadow_q;
        case (digit_d)
            2'd0:    nibble = shadow_d[3:0];
            2'd1:    nibble = shadow_d[7:4];
            2'd2:    nibble = shadow_d[11:8];
            default: nibble = shadow_d[15:12];
        endcase
        an_d  = wrap ? ~(4'b0001 << digit_d) : an_q;
        seg_d = wrap ? hex_to_seg(nibble) : seg_q;
    end

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        step      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sync2_q) begin
                    state_d   = ST_PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = ST_IDLE;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d = ST_PRESSED;
                    step    = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!sync2_q) begin
                    state_d   = ST_RELEASE_WAIT;
                    deb_cnt_d = '0;
                end
            end
            default: begin
                if (sync2_q) begin
                    state_d = ST_PRESSED;
                end else if (deb_cnt_q == DEB_MAX) begin
                    state_d = ST_IDLE;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
        endcase
        sel_d     = step ? sel_q + 2'd1 : sel_q;
        sel_led_d = 4'b0001 << sel_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scan_cnt_q <= '0;
            digit_q    <= 2'd0;
            shadow_q   <= 16'h0000;
            an_q       <= 4'b1110;
            seg_q      <= 8'hC0;
            sel_q      <= 2'd0;
            sel_led_q  <= 4'b0001;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            state_q    <= ST_IDLE;
            deb_cnt_q  <= '0;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            shadow_q   <= shadow_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            sel_q      <= sel_d;
            sel_led_q  <= sel_led_d;
            sync1_q    <= btn_next;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign sel_led = sel_led_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_reg_display.sv
// ============================================================================
// Module   : tb_cpu_reg_display
// Purpose  : Directed self-checking bench for cpu_reg_display.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_reg_display;

    logic        clk;
    logic        reset;
    logic [15:0] a0, v0, sp, ra;
    logic        btn_next;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic [3:0]  sel_led;

    int tests;
    int fails;
    int cyc;

    cpu_reg_display #(
        .SCAN_DIV   (4),
        .DEB_CYCLES (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .a0       (a0),
        .v0       (v0),
        .sp       (sp),
        .ra       (ra),
        .btn_next (btn_next),
        .an       (an),
        .seg      (seg),
        .sel_led  (sel_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edges since the last reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic goto_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int hold);
        btn_next = 1'b1;
        wait_cycles(hold);
        btn_next = 1'b0;
        wait_cycles(30);
    endtask

    task automatic test_reset;
        logic [3:0] exp_an;
        wait_cycles(3);
        tests++;
        if (an !== 4'b1110 || seg !== 8'hC0 || sel_led !== 4'b0001) begin
            $display("FAIL reset_hold: an=%b seg=%h sel_led=%b, want 1110 C0 0001", an, seg, sel_led);
            fails++;
        end
        reset = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) wait_cycles(1);
            exp_an = (k < 4) ? 4'b1110 : 4'b1101;
            tests++;
            if (an !== exp_an || seg !== 8'hC0 || sel_led !== 4'b0001) begin
                $display("FAIL reset_release_%0d: an=%b seg=%h sel_led=%b, want %b C0 0001",
                         k, an, seg, sel_led, exp_an);
                fails++;
            end
        end
    endtask

    task automatic test_scan_frame;
        logic [3:0] exp_an [4];
        logic [7:0] exp_seg [4];
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{8'h8E, 8'hA4, 8'h88, 8'hF9};
        goto_edge(15);
        tests++;
        if (an !== 4'b0111 || seg !== 8'hC0) begin
            $display("FAIL pre_boundary: an=%b seg=%h, want 0111 C0", an, seg);
            fails++;
        end
        for (int i = 0; i < 5; i++) begin
            goto_edge(16 + 4 * i);
            tests++;
            if (an !== exp_an[i % 4] || seg !== exp_seg[i % 4]) begin
                $display("FAIL frame_slot_%0d: an=%b seg=%h, want %b %h",
                         i, an, seg, exp_an[i % 4], exp_seg[i % 4]);
                fails++;
            end
        end
    endtask

    task automatic test_snapshot;
        logic [3:0] exp_an [8];
        logic [7:0] exp_seg [8];
        exp_an  = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        exp_seg = '{8'hA4, 8'h88, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        goto_edge(33);
        a0 = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            goto_edge(36 + 4 * i);
            tests++;
            if (an !== exp_an[i] || seg !== exp_seg[i]) begin
                $display("FAIL snapshot_slot_%0d: an=%b seg=%h, want %b %h",
                         i, an, seg, exp_an[i], exp_seg[i]);
                fails++;
            end
        end
    endtask

    task automatic test_button;
        logic [3:0] exp_led [3];
        exp_led = '{4'b0100, 4'b1000, 4'b0001};
        press(3);
        tests++;
        if (sel_led !== 4'b0001) begin
            $display("FAIL glitch_3: sel_led=%b, want 0001", sel_led);
            fails++;
        end
        press(7);
        tests++;
        if (sel_led !== 4'b0001) begin
            $display("FAIL glitch_7: sel_led=%b, want 0001", sel_led);
            fails++;
        end
        btn_next = 1'b1;
        wait_cycles(100);
        tests++;
        if (sel_led !== 4'b0010) begin
            $display("FAIL held_100: sel_led=%b, want 0010", sel_led);
            fails++;
        end
        btn_next = 1'b0;
        wait_cycles(30);
        tests++;
        if (sel_led !== 4'b0010) begin
            $display("FAIL after_hold_release: sel_led=%b, want 0010", sel_led);
            fails++;
        end
        for (int i = 0; i < 3; i++) begin
            press(30);
            tests++;
            if (sel_led !== exp_led[i]) begin
                $display("FAIL press_%0d: sel_led=%b, want %b", i + 2, sel_led, exp_led[i]);
                fails++;
            end
        end
    endtask

    task automatic test_sp_frame;
        logic [3:0] exp_an [4];
        logic [7:0] exp_seg [4];
        int b;
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        exp_seg = '{8'h8E, 8'h86, 8'h86, 8'h83};
        sp = 16'hBEEF;
        press(30);
        press(30);
        tests++;
        if (sel_led !== 4'b0100) begin
            $display("FAIL sel_sp: sel_led=%b, want 0100", sel_led);
            fails++;
        end
        b = (cyc / 16 + 1) * 16;
        for (int i = 0; i < 4; i++) begin
            goto_edge(b + 4 * i);
            tests++;
            if (an !== exp_an[i] || seg !== exp_seg[i]) begin
                $display("FAIL sp_slot_%0d: an=%b seg=%h, want %b %h",
                         i, an, seg, exp_an[i], exp_seg[i]);
                fails++;
            end
        end
    endtask

    task automatic test_reset_async;
        int b;
        b = (cyc / 16 + 1) * 16;
        goto_edge(b + 1);
        btn_next = 1'b1;
        goto_edge(b + 6);
        reset = 1'b0;
        #1;
        tests++;
        if (an !== 4'b1110 || seg !== 8'hC0 || sel_led !== 4'b0001) begin
            $display("FAIL async_reset: an=%b seg=%h sel_led=%b, want 1110 C0 0001", an, seg, sel_led);
            fails++;
        end
        btn_next = 1'b0;
        wait_cycles(3);
        reset = 1'b1;
        wait_cycles(40);
        tests++;
        if (sel_led !== 4'b0001) begin
            $display("FAIL no_step_after_reset: sel_led=%b, want 0001", sel_led);
            fails++;
        end
        tests++;
        if (an !== 4'b1011 || seg !== 8'hC0) begin
            $display("FAIL scan_after_reset: an=%b seg=%h, want 1011 C0", an, seg);
            fails++;
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        reset    = 1'b0;
        btn_next = 1'b0;
        a0       = 16'h1A2F;
        v0       = 16'h0000;
        sp       = 16'h0000;
        ra       = 16'h0000;
        test_reset;
        test_scan_frame;
        test_snapshot;
        test_button;
        test_sp_frame;
        test_reset_async;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
